// File: rtl/a2d_scan_ctrl.sv
// Round-robin scan controller for an ADC128S-style A2D behind a 16-bit SPI master.
// Each channel needs a select transaction and a read transaction; results are kept per channel.
module a2d_scan_ctrl #(
  parameter int NUM_CH  = 8,
  parameter int GAP_CYC = 4,
  parameter int TMO_CYC = 1023
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  output logic        spi_wrt,
  output logic [15:0] spi_cmd,
  input  logic        spi_done,
  input  logic [15:0] spi_rd_data,
  input  logic [2:0]  rd_ch,
  output logic [11:0] rd_res,
  output logic [7:0]  res_vld,
  output logic        scan_done,
  output logic        busy,
  output logic        err
);

  localparam int GAP_W = $clog2(GAP_CYC + 1);
  localparam int TMO_W = $clog2(TMO_CYC + 1);
  localparam logic [2:0]       LAST_CH  = 3'(NUM_CH - 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYC - 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TMO_CYC - 1);

  typedef enum logic [2:0] {
    IDLE, SEL_WRT, SEL_WAIT, SEL_GAP, RD_WRT, RD_WAIT, STORE, RD_GAP
  } state_t;

  state_t           state;
  logic [2:0]       ch;
  logic [GAP_W-1:0] gap_cnt;
  logic [TMO_W-1:0] tmo_cnt;
  logic [11:0]      rd_data_p0;
  logic [11:0]      res [8];
  logic [3:0]       unused_rd_hi;

  // The converter only returns 12 significant bits; the top nibble is always zero.
  assign unused_rd_hi = spi_rd_data[15:12];

  function automatic logic [15:0] sel_cmd(input logic [2:0] c);
    return {2'b00, c, 11'h000};
  endfunction

  function automatic logic [2:0] next_ch(input logic [2:0] c);
    return (c == LAST_CH) ? 3'd0 : c + 3'd1;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      ch         <= 3'd0;
      gap_cnt    <= '0;
      tmo_cnt    <= '0;
      spi_wrt    <= 1'b0;
      spi_cmd    <= 16'h0000;
      scan_done  <= 1'b0;
      err        <= 1'b0;
      res_vld    <= 8'h00;
      rd_data_p0 <= 12'h000;
      for (int i = 0; i < 8; i++) res[i] <= 12'h000;
    end else begin
      spi_wrt   <= 1'b0;
      scan_done <= 1'b0;
      case (state)
        IDLE: begin
          ch <= 3'd0;
          if (en) begin
            state   <= SEL_WRT;
            spi_wrt <= 1'b1;
            spi_cmd <= sel_cmd(3'd0);
          end
        end
        SEL_WRT: begin
          state   <= SEL_WAIT;
          tmo_cnt <= '0;
        end
        SEL_WAIT: begin
          if (spi_done) begin
            state   <= SEL_GAP;
            gap_cnt <= '0;
          end else if (tmo_cnt == TMO_LAST) begin
            err     <= 1'b1;
            state   <= RD_GAP;
            gap_cnt <= '0;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
        end
        SEL_GAP: begin
          if (gap_cnt == GAP_LAST) begin
            state   <= RD_WRT;
            spi_wrt <= 1'b1;
            spi_cmd <= sel_cmd(ch);
          end else begin
            gap_cnt <= gap_cnt + 1'b1;
          end
        end
        RD_WRT: begin
          state   <= RD_WAIT;
          tmo_cnt <= '0;
        end
        // stage p0: conversion result captured on done, written to the file one cycle later
        RD_WAIT: begin
          if (spi_done) begin
            rd_data_p0 <= spi_rd_data[11:0];
            state      <= STORE;
          end else if (tmo_cnt == TMO_LAST) begin
            err     <= 1'b1;
            state   <= RD_GAP;
            gap_cnt <= '0;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
        end
        STORE: begin
          res[ch]     <= rd_data_p0;
          res_vld[ch] <= 1'b1;
          if (ch == LAST_CH) scan_done <= 1'b1;
          state   <= RD_GAP;
          gap_cnt <= '0;
        end
        RD_GAP: begin
          if (gap_cnt == GAP_LAST) begin
            if (en) begin
              ch      <= next_ch(ch);
              state   <= SEL_WRT;
              spi_wrt <= 1'b1;
              spi_cmd <= sel_cmd(next_ch(ch));
            end else begin
              ch    <= 3'd0;
              state <= IDLE;
            end
          end else begin
            gap_cnt <= gap_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign rd_res = res[rd_ch];
  assign busy   = (state != IDLE);

endmodule

// File: tb/tb_a2d_scan_ctrl.sv
// Directed bench for a2d_scan_ctrl: 8-channel instance plus a 3-channel instance,
// each driven by a small SPI master model that answers 16'h0ABC + channel.
`timescale 1ns/1ps
module tb_a2d_scan_ctrl;

  logic        clk;
  logic        rst_n, en, en2;
  logic        spi_wrt, spi_wrt2;
  logic [15:0] spi_cmd, spi_cmd2;
  logic        spi_done, spi_done2;
  logic [15:0] spi_rd_data, spi_rd_data2;
  logic [2:0]  rd_ch, rd_ch2;
  logic [11:0] rd_res, rd_res2;
  logic [7:0]  res_vld, res_vld2;
  logic        scan_done, scan_done2, busy, busy2, err, err2;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic [15:0] wrt_cmd[$];
  int          wrt_cyc[$];
  int          done_cyc[$];
  int          scan_at[$];
  int          scan_cnt;
  logic [15:0] wrt_cmd2[$];
  int          scan_at2[$];
  int          scan_cnt2;
  logic        hold5;
  logic [15:0] dofs;

  a2d_scan_ctrl dut (
    .clk(clk), .rst_n(rst_n), .en(en),
    .spi_wrt(spi_wrt), .spi_cmd(spi_cmd), .spi_done(spi_done), .spi_rd_data(spi_rd_data),
    .rd_ch(rd_ch), .rd_res(rd_res), .res_vld(res_vld),
    .scan_done(scan_done), .busy(busy), .err(err)
  );

  a2d_scan_ctrl #(.NUM_CH(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .en(en2),
    .spi_wrt(spi_wrt2), .spi_cmd(spi_cmd2), .spi_done(spi_done2), .spi_rd_data(spi_rd_data2),
    .rd_ch(rd_ch2), .rd_res(rd_res2), .res_vld(res_vld2),
    .scan_done(scan_done2), .busy(busy2), .err(err2)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // SPI master model for the 8-channel instance: done three cycles after wrt.
  initial begin
    int mcnt;
    mcnt = 0;
    spi_done = 1'b0;
    spi_rd_data = 16'h0000;
    forever begin
      @(negedge clk);
      cyc++;
      if (spi_wrt) begin
        wrt_cmd.push_back(spi_cmd);
        wrt_cyc.push_back(cyc);
      end
      if (scan_done) begin
        scan_cnt++;
        scan_at.push_back(wrt_cmd.size());
      end
      spi_done = 1'b0;
      if (!rst_n) mcnt = 0;
      else if (mcnt != 0) begin
        mcnt--;
        if (mcnt == 0) begin
          spi_done = 1'b1;
          spi_rd_data = 16'h0ABC + dofs + 16'(spi_cmd[13:11]);
          done_cyc.push_back(cyc);
        end
      end else if (spi_wrt) begin
        if (hold5 && spi_cmd[13:11] == 3'd5) hold5 = 1'b0;
        else mcnt = 3;
      end
    end
  end

  // Same model for the 3-channel instance.
  initial begin
    int mcnt2;
    mcnt2 = 0;
    spi_done2 = 1'b0;
    spi_rd_data2 = 16'h0000;
    forever begin
      @(negedge clk);
      if (spi_wrt2) wrt_cmd2.push_back(spi_cmd2);
      if (scan_done2) begin
        scan_cnt2++;
        scan_at2.push_back(wrt_cmd2.size());
      end
      spi_done2 = 1'b0;
      if (!rst_n) mcnt2 = 0;
      else if (mcnt2 != 0) begin
        mcnt2--;
        if (mcnt2 == 0) begin
          spi_done2 = 1'b1;
          spi_rd_data2 = 16'h0ABC + 16'(spi_cmd2[13:11]);
        end
      end else if (spi_wrt2) mcnt2 = 3;
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
  endtask

  task automatic clear_log();
    wrt_cmd.delete(); wrt_cyc.delete(); done_cyc.delete(); scan_at.delete();
    scan_cnt = 0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) tick();
    rd_ch = 3'd0;
    #1;
    checks++; if (spi_wrt !== 1'b0) begin errors++; $display("FAIL reset_wrt: got %b expected 0", spi_wrt); end
    checks++; if (spi_cmd !== 16'h0000) begin errors++; $display("FAIL reset_cmd: got %h expected 0000", spi_cmd); end
    checks++; if (res_vld !== 8'h00) begin errors++; $display("FAIL reset_vld: got %h expected 00", res_vld); end
    checks++; if ({scan_done, busy, err} !== 3'b000) begin errors++; $display("FAIL reset_flags: got %b expected 000", {scan_done, busy, err}); end
    checks++; if (rd_res !== 12'h000) begin errors++; $display("FAIL reset_res: got %h expected 000", rd_res); end
    checks++; if ({spi_wrt2, busy2, res_vld2} !== 10'h000) begin errors++; $display("FAIL reset_dut3: got %h expected 000", {spi_wrt2, busy2, res_vld2}); end
    rst_n = 1'b1;
    repeat (3) tick();
    checks++; if ({spi_wrt, busy} !== 2'b00) begin errors++; $display("FAIL idle_no_en: got %b expected 00", {spi_wrt, busy}); end
  endtask

  task automatic test_full_scan();
    int t0, n;
    clear_log();
    tick();
    t0 = cyc;
    en = 1'b1;
    n = 0;
    while (scan_cnt < 2 && n < 800) begin tick(); n++; end
    checks++; if (scan_cnt < 2) begin errors++; $display("FAIL scan_timeout: got %0d scans expected 2", scan_cnt); end
    checks++; if (wrt_cyc.size() == 0 || wrt_cyc[0] !== t0 + 1) begin errors++; $display("FAIL first_wrt_latency: got cycle %0d expected %0d", (wrt_cyc.size() > 0) ? wrt_cyc[0] : -1, t0 + 1); end
    for (int i = 0; i < 16; i++) begin
      logic [15:0] exp_cmd;
      exp_cmd = 16'((i / 2) << 11);
      checks++;
      if (wrt_cmd.size() <= i || wrt_cmd[i] !== exp_cmd) begin
        errors++; $display("FAIL cmd_seq[%0d]: got %h expected %h", i, (wrt_cmd.size() > i) ? wrt_cmd[i] : 16'hxxxx, exp_cmd);
      end
    end
    checks++; if (scan_at.size() < 2 || scan_at[0] !== 16 || scan_at[1] !== 32) begin errors++; $display("FAIL scan_done_spacing: got %p expected 16,32", scan_at); end
    checks++; if (res_vld !== 8'hFF) begin errors++; $display("FAIL full_vld: got %h expected FF", res_vld); end
    rd_ch = 3'd3; #1;
    checks++; if (rd_res !== 12'hABF) begin errors++; $display("FAIL res3: got %h expected ABF", rd_res); end
    rd_ch = 3'd7; #1;
    checks++; if (rd_res !== 12'hAC3) begin errors++; $display("FAIL res7: got %h expected AC3", rd_res); end
  endtask

  task automatic test_gap();
    checks++; if (wrt_cyc.size() < 3 || done_cyc.size() < 2 || wrt_cyc[1] - done_cyc[0] !== 5) begin errors++; $display("FAIL gap_after_sel: got %0d expected 5", (wrt_cyc.size() > 1 && done_cyc.size() > 0) ? wrt_cyc[1] - done_cyc[0] : -1); end
    checks++; if (wrt_cyc.size() < 3 || done_cyc.size() < 2 || wrt_cyc[2] - done_cyc[1] !== 6) begin errors++; $display("FAIL gap_after_rd: got %0d expected 6", (wrt_cyc.size() > 2 && done_cyc.size() > 1) ? wrt_cyc[2] - done_cyc[1] : -1); end
  endtask

  task automatic test_en_drop();
    int s0, s1, n;
    bit found;
    dofs = 16'h0100;
    s0 = wrt_cmd.size();
    found = 1'b0;
    n = 0;
    while (!found && n < 400) begin
      tick(); n++;
      if (wrt_cmd.size() > s0 && wrt_cmd.size() % 2 == 0 && wrt_cmd[$] == 16'h1000) found = 1'b1;
    end
    checks++; if (!found) begin errors++; $display("FAIL en_drop_find_ch2_read: got none expected read wrt of ch2"); end
    tick();
    en = 1'b0;
    n = 0;
    while (busy && n < 100) begin tick(); n++; end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL en_drop_busy: got %b expected 0", busy); end
    rd_ch = 3'd2; #1;
    checks++; if (rd_res !== 12'hBBE) begin errors++; $display("FAIL en_drop_res2: got %h expected BBE", rd_res); end
    rd_ch = 3'd3; #1;
    checks++; if (rd_res !== 12'hABF) begin errors++; $display("FAIL en_drop_res3: got %h expected ABF", rd_res); end
    s1 = wrt_cmd.size();
    repeat (20) tick();
    checks++; if (wrt_cmd.size() !== s1 || busy !== 1'b0) begin errors++; $display("FAIL idle_quiet: got %0d wrts busy %b expected %0d wrts busy 0", wrt_cmd.size(), busy, s1); end
    en = 1'b1;
    n = 0;
    while (wrt_cmd.size() <= s1 && n < 10) begin tick(); n++; end
    checks++; if (wrt_cmd.size() <= s1 || wrt_cmd[s1] !== 16'h0000) begin errors++; $display("FAIL reenable_cmd: got %h expected 0000", (wrt_cmd.size() > s1) ? wrt_cmd[s1] : 16'hxxxx); end
    dofs = 16'h0000;
  endtask

  task automatic test_timeout();
    int n, s;
    en = 1'b0;
    do_reset();
    clear_log();
    hold5 = 1'b1;
    en = 1'b1;
    n = 0;
    while (err !== 1'b1 && n < 2500) begin tick(); n++; end
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL tmo_err_set: got %b expected 1", err); end
    checks++; if (wrt_cmd.size() == 0 || wrt_cmd[$] !== 16'h2800) begin errors++; $display("FAIL tmo_on_ch5: got %h expected 2800", (wrt_cmd.size() > 0) ? wrt_cmd[$] : 16'hxxxx); end
    checks++; if (wrt_cyc.size() == 0 || cyc - wrt_cyc[$] !== 1024) begin errors++; $display("FAIL tmo_latency: got %0d expected 1024", (wrt_cyc.size() > 0) ? cyc - wrt_cyc[$] : -1); end
    s = wrt_cmd.size();
    n = 0;
    while (wrt_cmd.size() <= s && n < 20) begin tick(); n++; end
    checks++; if (wrt_cmd.size() <= s || wrt_cmd[s] !== 16'h3000) begin errors++; $display("FAIL tmo_next_cmd: got %h expected 3000", (wrt_cmd.size() > s) ? wrt_cmd[s] : 16'hxxxx); end
    n = 0;
    while (scan_cnt < 1 && n < 400) begin tick(); n++; end
    checks++; if (res_vld !== 8'hDF) begin errors++; $display("FAIL tmo_vld: got %h expected DF", res_vld); end
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL tmo_err_sticky: got %b expected 1", err); end
    rd_ch = 3'd5; #1;
    checks++; if (rd_res !== 12'h000) begin errors++; $display("FAIL tmo_res5: got %h expected 000", rd_res); end
    rd_ch = 3'd6; #1;
    checks++; if (rd_res !== 12'hAC2) begin errors++; $display("FAIL tmo_res6: got %h expected AC2", rd_res); end
    en = 1'b0;
    do_reset();
    #1;
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL tmo_err_clear: got %b expected 0", err); end
  endtask

  task automatic test_mid_reset();
    int n;
    clear_log();
    en = 1'b1;
    n = 0;
    while (wrt_cmd.size() < 3 && n < 100) begin tick(); n++; end
    checks++; if (spi_wrt !== 1'b1) begin errors++; $display("FAIL mid_reset_pre_wrt: got %b expected 1", spi_wrt); end
    rst_n = 1'b0;
    rd_ch = 3'd0;
    #1;
    checks++; if (spi_wrt !== 1'b0 || spi_cmd !== 16'h0000) begin errors++; $display("FAIL mid_reset_spi: got %b/%h expected 0/0000", spi_wrt, spi_cmd); end
    checks++; if ({busy, err, scan_done, res_vld} !== 11'h000 || rd_res !== 12'h000) begin errors++; $display("FAIL mid_reset_state: got %h/%h expected 000/000", {busy, err, scan_done, res_vld}, rd_res); end
    repeat (2) tick();
    clear_log();
    rst_n = 1'b1;
    n = 0;
    while (wrt_cmd.size() < 1 && n < 10) begin tick(); n++; end
    checks++; if (wrt_cmd.size() < 1 || wrt_cmd[0] !== 16'h0000) begin errors++; $display("FAIL mid_reset_restart: got %h expected 0000", (wrt_cmd.size() > 0) ? wrt_cmd[0] : 16'hxxxx); end
    en = 1'b0;
  endtask

  task automatic test_num_ch3();
    int n;
    wrt_cmd2.delete(); scan_at2.delete(); scan_cnt2 = 0;
    en2 = 1'b1;
    n = 0;
    while (scan_cnt2 < 1 && n < 300) begin tick(); n++; end
    checks++; if (res_vld2 !== 8'h07) begin errors++; $display("FAIL ch3_vld: got %h expected 07", res_vld2); end
    checks++; if (scan_at2.size() < 1 || scan_at2[0] !== 6) begin errors++; $display("FAIL ch3_scan_done: got %p expected 6", scan_at2); end
    n = 0;
    while (wrt_cmd2.size() < 7 && n < 20) begin tick(); n++; end
    checks++; if (wrt_cmd2.size() < 7 || wrt_cmd2[4] !== 16'h1000 || wrt_cmd2[6] !== 16'h0000) begin errors++; $display("FAIL ch3_wrap: got %p expected ch2 then ch0", wrt_cmd2); end
    rd_ch2 = 3'd2; #1;
    checks++; if (rd_res2 !== 12'hABE) begin errors++; $display("FAIL ch3_res2: got %h expected ABE", rd_res2); end
    rd_ch2 = 3'd3; #1;
    checks++; if (rd_res2 !== 12'h000 || err2 !== 1'b0) begin errors++; $display("FAIL ch3_res3: got %h err %b expected 000 err 0", rd_res2, err2); end
    en2 = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b0; en2 = 1'b0;
    rd_ch = 3'd0; rd_ch2 = 3'd0;
    hold5 = 1'b0; dofs = 16'h0000;
    scan_cnt = 0; scan_cnt2 = 0;
    test_reset();
    test_full_scan();
    test_gap();
    test_en_drop();
    test_timeout();
    test_mid_reset();
    test_num_ch3();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
